// File: rtl/mac_tile_scheduler_if.sv
// Handshake bundle between the tile scheduler, its job source,
// the MAC controller and the result consumer.
interface mac_tile_scheduler_if #(
  parameter int TILE_SIZE = 4,
  parameter int ACC_WIDTH = 32,
  parameter int TCNT_W    = 7
);
  localparam int VW = TILE_SIZE * ACC_WIDTH;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [TCNT_W-1:0] cmd_ntile;
  logic              mac_start_valid;
  logic              mac_start_ready;
  logic              mac_done_valid;
  logic              mac_done_ready;
  logic [VW-1:0]     mac_result;
  logic              res_valid;
  logic              res_ready;
  logic [VW-1:0]     res_data;
  logic [TCNT_W-1:0] res_idx;
  logic              res_last;
  logic              busy;
  logic              done_pulse;
  logic              err_timeout;
  logic [31:0]       job_cycles;

  modport master (
    output cmd_valid, cmd_ntile, mac_start_ready,
    output mac_done_valid, mac_result, res_ready,
    input  cmd_ready, mac_start_valid, mac_done_ready,
    input  res_valid, res_data, res_idx, res_last,
    input  busy, done_pulse, err_timeout, job_cycles
  );

  modport slave (
    input  cmd_valid, cmd_ntile, mac_start_ready,
    input  mac_done_valid, mac_result, res_ready,
    output cmd_ready, mac_start_valid, mac_done_ready,
    output res_valid, res_data, res_idx, res_last,
    output busy, done_pulse, err_timeout, job_cycles
  );
endinterface

// File: rtl/mac_tile_scheduler.sv
// Job sequencer for the MAC controller: issues N tile passes,
// holds each reduced vector and streams it out in tile order.
module mac_tile_scheduler #(
  parameter int TILE_SIZE   = 4,
  parameter int ACC_WIDTH   = 32,
  parameter int N_TILE_MAX  = 64,
  parameter int TCNT_W      = 7,
  parameter int TIMEOUT_CYC = 1024
) (
  input logic clk,
  input logic rst,
  mac_tile_scheduler_if.slave bus
);
  localparam int VW   = TILE_SIZE * ACC_WIDTH;
  localparam int TO_W = $clog2(TIMEOUT_CYC);

  typedef enum logic [1:0] {
    IDLE, ISSUE, WAIT_RES, FLUSH
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [TCNT_W-1:0] ntile;
  logic [TCNT_W-1:0] tile_idx;
  logic [TCNT_W-1:0] ntile_in;
  logic [TO_W-1:0]   tcnt;
  logic              hold_valid;
  logic [VW-1:0]     hold_data;
  logic [TCNT_W-1:0] hold_idx;
  logic              hold_last;
  logic              zero_pend;
  logic              err;
  logic [31:0]       cyc;
  logic              cmd_hs;
  logic              start_hs;
  logic              done_hs;
  logic              res_hs;
  logic              is_last;
  logic              tmo;

  assign ntile_in = (bus.cmd_ntile > TCNT_W'(N_TILE_MAX))
                  ? TCNT_W'(N_TILE_MAX) : bus.cmd_ntile;
  assign cmd_hs   = bus.cmd_valid && (state == IDLE);
  assign start_hs = bus.mac_start_valid && bus.mac_start_ready;
  assign done_hs  = (state == WAIT_RES) && bus.mac_done_valid
                  && bus.mac_done_ready;
  assign res_hs   = hold_valid && bus.res_ready;
  assign is_last  = (tile_idx == ntile - TCNT_W'(1));
  // A done handshake in the final timeout cycle wins over the error.
  assign tmo      = (state == WAIT_RES) && !done_hs
                  && (tcnt == TO_W'(TIMEOUT_CYC - 1));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state decode.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:     if (cmd_hs && ntile_in != '0) state_nx = ISSUE;
      ISSUE:    if (start_hs) state_nx = WAIT_RES;
      WAIT_RES: begin
        if (done_hs)  state_nx = is_last ? FLUSH : ISSUE;
        else if (tmo) state_nx = FLUSH;
      end
      FLUSH:    if (!hold_valid) state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  // Output decode; the MAC gates start-ready with done-ready,
  // so done-ready must be up while a pass is being issued.
  always_comb begin
    bus.cmd_ready       = 1'b0;
    bus.mac_start_valid = 1'b0;
    bus.mac_done_ready  = 1'b0;
    bus.busy            = (state != IDLE);
    bus.done_pulse      = zero_pend;
    unique case (state)
      IDLE:     bus.cmd_ready = 1'b1;
      ISSUE: begin
        bus.mac_start_valid = 1'b1;
        bus.mac_done_ready  = 1'b1;
      end
      WAIT_RES: bus.mac_done_ready = !hold_valid || bus.res_ready;
      FLUSH:    bus.done_pulse = !hold_valid;
      default: ;
    endcase
  end

  assign bus.res_valid   = hold_valid;
  assign bus.res_data    = hold_data;
  assign bus.res_idx     = hold_idx;
  assign bus.res_last    = hold_last;
  assign bus.err_timeout = err;
  assign bus.job_cycles  = cyc;

  // Job bookkeeping: pass count, tile index, error and cycle count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ntile     <= '0;
      tile_idx  <= '0;
      zero_pend <= 1'b0;
      err       <= 1'b0;
      cyc       <= '0;
    end else begin
      zero_pend <= cmd_hs && (ntile_in == '0);
      if (cmd_hs) begin
        ntile    <= ntile_in;
        tile_idx <= '0;
        err      <= 1'b0;
        cyc      <= '0;
      end else begin
        if (done_hs && !is_last) tile_idx <= tile_idx + TCNT_W'(1);
        if (tmo) err <= 1'b1;
        if (bus.busy && cyc != 32'hFFFF_FFFF) cyc <= cyc + 32'd1;
      end
    end
  end

  // Per-pass timeout counter; stops before wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) tcnt <= '0;
    else if (start_hs) tcnt <= '0;
    else if ((state == WAIT_RES) && !done_hs && !tmo)
      tcnt <= tcnt + TO_W'(1);
  end

  // Hold register; a reload wins over a same-cycle drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_valid <= 1'b0;
      hold_data  <= '0;
      hold_idx   <= '0;
      hold_last  <= 1'b0;
    end else if (done_hs) begin
      hold_valid <= 1'b1;
      hold_data  <= bus.mac_result;
      hold_idx   <= tile_idx;
      hold_last  <= is_last;
    end else if (res_hs) begin
      hold_valid <= 1'b0;
    end
  end
endmodule

// File: doc/mac_tile_scheduler.md
# mac_tile_scheduler

Job-level sequencer in front of the MAC/memory controller of the Mamba SSM datapath. It accepts a command of N tile passes, issues one start handshake per pass, collects each finished `TILE_SIZE`-lane reduced vector, and streams the vectors out in tile order with index and last flags. It also provides timeout supervision and a per-job cycle counter. The scheduler owns both AXI-Stream handshake pairs of the MAC controller, so no other requester may drive them.

## Interface
Parameters:
- `TILE_SIZE`, 4: lanes per reduced vector.
- `ACC_WIDTH`, 32: bits per lane.
- `N_TILE_MAX`, 64: maximum passes per job.
- `TCNT_W`, 7: width of tile count and tile index; must hold `N_TILE_MAX`.
- `TIMEOUT_CYC`, 1024: maximum cycles allowed in WAIT_RES per pass.

Ports:
- `clk`  in  1  sole clock; all logic is rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `cmd_valid`  in  1  job request.
- `cmd_ready`  out  1  high only in IDLE.
- `cmd_ntile`  in  TCNT_W  passes requested; values above `N_TILE_MAX` are clamped to `N_TILE_MAX`.
- `mac_start_valid`  out  1  drives the MAC `s_axis_TVALID`.
- `mac_start_ready`  in  1  from the MAC `s_axis_TREADY`.
- `mac_done_valid`  in  1  from the MAC `m_axis_TVALID`.
- `mac_done_ready`  out  1  drives the MAC `m_axis_TREADY`.
- `mac_result`  in  TILE_SIZE*ACC_WIDTH  flattened reduced vector; lane k is at bits [k*ACC_WIDTH +: ACC_WIDTH].
- `res_valid`, `res_ready`  out, in  1  result stream handshake.
- `res_data`  out  TILE_SIZE*ACC_WIDTH  captured vector.
- `res_idx`  out  TCNT_W  pass index, 0-based.
- `res_last`  out  1  marks the final pass of the job.
- `busy`  out  1  high whenever the state is not IDLE.
- `done_pulse`  out  1  one-cycle pulse at job end.
- `err_timeout`  out  1  sticky; cleared on the next command accept.
- `job_cycles`  out  32  cycle count of the last job; saturates at 0xFFFF_FFFF.

## Operation
States: IDLE, ISSUE, WAIT_RES, FLUSH.

- **IDLE**
  - `cmd_ready`=1.
  - On `cmd_valid&&cmd_ready`: latch `ntile`, set `tile_idx`=0, clear `err_timeout`, clear `job_cycles`.
  - `ntile`==0: stay in IDLE; `done_pulse` fires the next cycle.
  - Otherwise go to ISSUE.
- **ISSUE**
  - `mac_start_valid`=1 and `mac_done_ready`=1. The MAC gates its `s_axis_TREADY` with `m_axis_TREADY`, so `mac_done_ready` must be high here.
  - On the start handshake: clear the timeout counter, go to WAIT_RES.
- **WAIT_RES**
  - `mac_done_ready` = `!hold_valid || res_ready`.
  - On the done handshake:
    - load the hold register with `mac_result`, `tile_idx`, and last = (`tile_idx`==`ntile`-1);
    - set `hold_valid`;
    - if last, go to FLUSH; otherwise increment `tile_idx` and go to ISSUE.
  - The timeout counter increments every cycle without a done handshake. When it reaches `TIMEOUT_CYC`-1: set `err_timeout`, go to FLUSH, issue no further passes.
- **FLUSH**
  - Wait for `hold_valid`==0, then go to IDLE with `done_pulse`=1 in the same cycle.
- **Result port**
  - `res_valid`=`hold_valid`; `res_data`, `res_idx`, `res_last` come from the hold register.
  - A `res_valid&&res_ready` handshake clears `hold_valid`, unless a done handshake in the same cycle reloads it.
  - Outputs are stable while `res_valid && !res_ready`.
- **job_cycles**: increments every cycle in which `busy`=1 and holds its value in IDLE.

## Timing
- **Reset values**: IDLE state.
  - `cmd_ready`=1.
  - 0 on all of: `mac_start_valid`, `mac_done_ready`, `res_valid`, `res_data`, `res_idx`, `res_last`, `busy`, `done_pulse`, `err_timeout`, `job_cycles`.
- **Reset mid-job**: everything returns to reset values immediately and the captured result is discarded. The MAC is reset separately.
- **Latencies**:
  - command accept -> `mac_start_valid`: next cycle;
  - done handshake -> `res_valid`: next cycle;
  - non-last done handshake -> next `mac_start_valid`: next cycle.
- **Control outputs**: all are combinational decodes of registered state and `hold_valid`, except `mac_done_ready`, which also depends on `res_ready`. The hold register and all counters are registered.
- **Simultaneous events**:
  - done handshake and result handshake in the same cycle: the new vector replaces the old one and `hold_valid` stays 1;
  - timeout in the same cycle as a done handshake: the handshake wins and no error is flagged.
- **Backpressure**:
  - `res_ready`=0 with `hold_valid`=1 deasserts `mac_done_ready`, which stalls the MAC;
  - time spent stalled still counts toward the timeout.
- **Counters**: `tile_idx` never exceeds `ntile`-1. The timeout counter is `$clog2(TIMEOUT_CYC)` bits wide and never wraps.

## Test plan
- **Single pass**: `cmd_ntile`=1, MAC returns lanes {1,2,3,4}, `res_ready`=1. Expect `res_data` lanes 1,2,3,4, `res_idx`=0, `res_last`=1, `done_pulse` once, `busy` low afterwards.
- **Multi-pass ordering**: `cmd_ntile`=5, MAC model with random latency 70-90 cycles. Expect exactly 5 results with idx 0..4, `res_last` only on idx 4, and 5 start handshakes.
- **Backpressure**: `res_ready` held 0 for 200 cycles after the first result. Expect `mac_done_ready` low, `res_data` stable, no lost or duplicated vector; all 3 of 3 results eventually delivered.
- **Timeout**: MAC never asserts done, `TIMEOUT_CYC`=1024. Expect `err_timeout`=1 exactly 1024 cycles after the start handshake, then `done_pulse` and return to IDLE. `err_timeout` clears on the next command accept.
- **Edge commands**: `cmd_ntile`=0 gives `done_pulse` the next cycle with no start handshake. `cmd_ntile`=100 runs exactly 64 passes.
- **Reset mid-job**: assert `rst` during WAIT_RES of pass 2. All outputs go to reset values asynchronously; a new `cmd_ntile`=2 then completes normally, with `job_cycles` equal to the observed busy cycles.
